bounce_motion: RTL and testbench

//   Per-frame position engine for the bouncing sprite in tt_um_sjsu. Sits between
//   the VGA timing generator (upstream, supplies vsync) and the pixel renderer
//   (downstream, consumes x_pos/y_pos). Once per frame it advances the sprite by
//   the selected speed, reflects off the screen edges and reports bounce events.

---
 rtl/bounce_motion.sv | 128 ++++++++++++
 tb/tb_bounce_motion.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bounce_motion.sv
// Per-frame position engine for the bouncing sprite: advances x/y once per vsync,
// reflects off the screen edges and reports bounce/corner events with a hit counter.
module bounce_motion #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 32,
    parameter int X_INIT   = 100,
    parameter int Y_INIT   = 50,
    parameter int STEP_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               pause,
    input  logic [STEP_W-1:0]  speed,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic               dir_x,
    output logic               dir_y,
    output logic               bounce,
    output logic               corner,
    output logic [7:0]         bounce_count
);

    localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W - SPRITE_W);
    localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H - SPRITE_H);

    typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               dir;
        logic               hit;
    } axis_t;

    state_t            state, state_nxt;
    logic              vsync_q;
    logic              frame_edge;
    logic [STEP_W-1:0] s;
    axis_t             ax, ay;

    // One extra bit of headroom keeps pos+step from wrapping before the edge compare.
    function automatic axis_t step_axis(input logic [COORD_W-1:0] pos,
                                        input logic               dir,
                                        input logic [STEP_W-1:0]  step,
                                        input logic [COORD_W:0]   lim);
        logic [COORD_W:0] p;
        logic [COORD_W:0] d;
        logic [COORD_W:0] sum;
        logic [COORD_W:0] diff;
        axis_t            r;
        p    = {1'b0, pos};
        d    = (COORD_W+1)'(step);
        sum  = p + d;
        diff = p - d;
        r    = '{pos: pos, dir: dir, hit: 1'b0};
        if (dir) begin
            if (sum >= lim) r = '{pos: lim[COORD_W-1:0], dir: 1'b0, hit: 1'b1};
            else            r.pos = sum[COORD_W-1:0];
        end else begin
            if (p <= d) r = '{pos: '0, dir: 1'b1, hit: 1'b1};
            else        r.pos = diff[COORD_W-1:0];
        end
        return r;
    endfunction

    assign frame_edge = vsync_q & ~vsync;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_edge && !pause && speed != '0) state_nxt = STEP_X;
            STEP_X:  state_nxt = STEP_Y;
            STEP_Y:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q      <= 1'b1;
            s            <= '0;
            ax           <= '0;
            ay           <= '0;
            x_pos        <= COORD_W'(X_INIT);
            y_pos        <= COORD_W'(Y_INIT);
            dir_x        <= 1'b1;
            dir_y        <= 1'b1;
            bounce       <= 1'b0;
            corner       <= 1'b0;
            bounce_count <= '0;
        end else begin
            vsync_q <= vsync;
            bounce  <= 1'b0;
            corner  <= 1'b0;
            case (state)
                IDLE:   if (state_nxt == STEP_X) s <= speed;
                STEP_X: ax <= step_axis(x_pos, dir_x, s, X_LIM);
                STEP_Y: ay <= step_axis(y_pos, dir_y, s, Y_LIM);
                COMMIT: begin
                    // All outputs land on the same edge so the renderer never sees a half-update.
                    x_pos  <= ax.pos;
                    y_pos  <= ay.pos;
                    dir_x  <= ax.dir;
                    dir_y  <= ay.dir;
                    bounce <= ax.hit | ay.hit;
                    corner <= ax.hit & ay.hit;
                    if (ax.hit | ay.hit) bounce_count <= bounce_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_motion.sv
// Directed bench for bounce_motion: four instances with different start positions
// and screen sizes share clock, reset, vsync and pause; each has its own speed.
module tb_bounce_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b1;
    logic       pause = 1'b0;
    logic [2:0] speed [4];
    logic [9:0] x_pos [4];
    logic [9:0] y_pos [4];
    logic       dir_x [4];
    logic       dir_y [4];
    logic       bounce [4];
    logic       corner [4];
    logic [7:0] bcnt [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 0: default, 1: near right edge, 2: near bottom-right corner, 3: tiny screen (hit every frame)
    bounce_motion u_a (
        .clk(clk), .rst(rst), .vsync(vsync), .pause(pause), .speed(speed[0]),
        .x_pos(x_pos[0]), .y_pos(y_pos[0]), .dir_x(dir_x[0]), .dir_y(dir_y[0]),
        .bounce(bounce[0]), .corner(corner[0]), .bounce_count(bcnt[0]));

    bounce_motion #(.X_INIT(574)) u_b (
        .clk(clk), .rst(rst), .vsync(vsync), .pause(pause), .speed(speed[1]),
        .x_pos(x_pos[1]), .y_pos(y_pos[1]), .dir_x(dir_x[1]), .dir_y(dir_y[1]),
        .bounce(bounce[1]), .corner(corner[1]), .bounce_count(bcnt[1]));

    bounce_motion #(.X_INIT(574), .Y_INIT(446)) u_c (
        .clk(clk), .rst(rst), .vsync(vsync), .pause(pause), .speed(speed[2]),
        .x_pos(x_pos[2]), .y_pos(y_pos[2]), .dir_x(dir_x[2]), .dir_y(dir_y[2]),
        .bounce(bounce[2]), .corner(corner[2]), .bounce_count(bcnt[2]));

    bounce_motion #(.SCREEN_W(70), .SCREEN_H(40), .X_INIT(0), .Y_INIT(0)) u_w (
        .clk(clk), .rst(rst), .vsync(vsync), .pause(pause), .speed(speed[3]),
        .x_pos(x_pos[3]), .y_pos(y_pos[3]), .dir_x(dir_x[3]), .dir_y(dir_y[3]),
        .bounce(bounce[3]), .corner(corner[3]), .bounce_count(bcnt[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle vsync pulse; returns on the negedge where a triggered commit and its pulse are visible.
    task automatic frame();
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_speeds(input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] c, input logic [2:0] w);
        speed[0] = a; speed[1] = b; speed[2] = c; speed[3] = w;
    endtask

    initial begin
        logic seen;
        set_speeds(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_x", x_pos[0], 100);
        check("rst_y", y_pos[0], 50);
        check("rst_dir", {dir_x[0], dir_y[0]}, 2'b11);
        check("rst_cnt", bcnt[0], 0);
        check("rst_pulse", {bounce[0], corner[0]}, 0);

        // Plain move, with latency: unchanged two negedges after the vsync release
        set_speeds(3, 0, 0, 0);
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        repeat (2) @(negedge clk);
        check("lat_x_old", x_pos[0], 100);
        @(negedge clk);
        check("mv_x", x_pos[0], 103);
        check("mv_y", y_pos[0], 53);
        check("mv_bounce", bounce[0], 0);
        check("mv_cnt", bcnt[0], 0);
        check("spd0_b_x", x_pos[1], 574);

        // Right-edge hit
        set_speeds(0, 3, 0, 0);
        frame();
        check("rh_x", x_pos[1], 576);
        check("rh_y", y_pos[1], 53);
        check("rh_dirx", dir_x[1], 0);
        check("rh_bounce", bounce[1], 1);
        check("rh_corner", corner[1], 0);
        check("rh_cnt", bcnt[1], 1);
        @(negedge clk);
        check("rh_pulse_end", bounce[1], 0);
        frame();
        check("rh_back_x", x_pos[1], 573);
        check("rh_back_y", y_pos[1], 56);
        check("rh_back_bounce", bounce[1], 0);
        check("rh_back_cnt", bcnt[1], 1);

        // Corner hit
        set_speeds(0, 0, 2, 0);
        frame();
        check("cr_xy", {x_pos[2], y_pos[2]}, {10'd576, 10'd448});
        check("cr_dir", {dir_x[2], dir_y[2]}, 2'b00);
        check("cr_pulses", {bounce[2], corner[2]}, 2'b11);
        check("cr_cnt", bcnt[2], 1);
        @(negedge clk);
        check("cr_pulse_end", {bounce[2], corner[2]}, 2'b00);

        // Pause, then zero speed: nothing moves
        set_speeds(3, 0, 0, 0);
        pause = 1'b1;
        repeat (3) frame();
        check("pause_xy", {x_pos[0], y_pos[0]}, {10'd103, 10'd53});
        pause = 1'b0;
        set_speeds(0, 0, 0, 0);
        repeat (3) frame();
        check("spd0_xy", {x_pos[0], y_pos[0]}, {10'd103, 10'd53});

        // vsync held low for 1000 cycles gives a single update
        set_speeds(1, 0, 0, 0);
        @(negedge clk) vsync = 1'b0;
        repeat (1000) @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        check("hold_xy", {x_pos[0], y_pos[0]}, {10'd104, 10'd54});

        // Reset while in STEP_Y aborts the update
        set_speeds(1, 3, 0, 0);
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_a_xy", {x_pos[0], y_pos[0]}, {10'd100, 10'd50});
        check("abort_b_x", x_pos[1], 574);
        check("abort_b_dir", {dir_x[1], dir_y[1]}, 2'b11);
        check("abort_b_cnt", bcnt[1], 0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | bounce[1] | bounce[0];
        end
        check("abort_no_pulse", seen, 0);
        check("abort_b_hold", x_pos[1], 574);

        // Counter wrap on a tiny screen where every frame hits
        set_speeds(0, 0, 0, 7);
        frame();
        check("w1_xy", {x_pos[3], y_pos[3]}, {10'd6, 10'd7});
        check("w1_cnt", bcnt[3], 1);
        frame();
        check("w2_xy", {x_pos[3], y_pos[3]}, {10'd0, 10'd8});
        check("w2_corner", corner[3], 1);
        check("w2_cnt", bcnt[3], 2);
        repeat (253) frame();
        check("w255_cnt", bcnt[3], 255);
        frame();
        check("w256_wrap", bcnt[3], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
